sti_lane_serializer: RTL and testbench
======================================

Name: sti_lane_serializer

Overview:
Parametrised parallel-to-serial transmitter. It is the next generation of the STI stage that feeds the data-arrangement converter.
- Accepts DATA_W-bit words with per-word framing controls (length, fill, bit order, half select).
- Buffers accepted words in a small FIFO and emits each frame on LANES serial lanes with no gap between frames.
- Adds ready backpressure, overflow flagging, a last-beat marker and an end-of-stream done pulse.

Parameters:
DATA_W, 16, input word width; even, >=4
LANES, 1, serial output lanes per beat; 1, 2 or 4; must divide DATA_W/2
FIFO_DEPTH, 2, input buffer entries; power of 2, >=2

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  asynchronous, active-high reset
load  in  1  word offer strobe
pi_data  in  DATA_W  parallel word
pi_length  in  2  frame width code
pi_fill  in  1  1: data MSB-aligned in long frames; 0: LSB-aligned
pi_msb  in  1  1: MSB first; 0: LSB first
pi_low  in  1  half select when pi_length=0
pi_end  in  1  marks the word as last of the stream
pi_ready  out  1  FIFO can accept a word
so_data  out  LANES  serial beat
so_valid  out  1  so_data valid
so_last  out  1  final beat of the current frame
busy  out  1  FIFO non-empty or a frame in flight
done  out  1  one-cycle pulse at end of stream
err_ovf  out  1  sticky: load offered while pi_ready=0

Behaviour:
- Reset (async, active-high): every output is 0, including pi_ready. FIFO is flushed and the FSM goes to IDLE. Reset mid-frame aborts the frame; no so_last and no done are produced. pi_ready rises in the first cycle after reset deasserts.
- Accept: on a rising edge with load=1 and pi_ready=1, the entry {pi_end, pi_length, pi_fill, pi_msb, pi_low, pi_data} is pushed.
- pi_ready = !full, taken from the registered count. There is no same-cycle pass-through when full.
- A load seen while pi_ready=0 is dropped and sets err_ovf.
- Frame width F by pi_length: 0 -> DATA_W/2; 1 -> DATA_W; 2 -> 3*DATA_W/2; 3 -> 2*DATA_W.
- Frame content:
  - len 0: pi_low ? data[DATA_W/2-1:0] : data[DATA_W-1:DATA_W/2].
  - len 1: the data word as-is.
  - len 2/3, fill=1: data occupies the top DATA_W bits, zeros below.
  - len 2/3, fill=0: zeros above, data in the low DATA_W bits.
- Bit order: msb=1 sends bit F-1 first; msb=0 sends bit 0 first.
- Each beat carries the next LANES bits of that sequence. so_data[LANES-1] carries the earliest bit of the beat. A frame is F/LANES beats.
- FSM IDLE:
  - FIFO non-empty at an edge -> pop, load the shift register and beat counter, go to SHIFT.
  - First beat is visible after that edge, so a word accepted into an empty FIFO at edge N produces so_valid from edge N+1.
- FSM SHIFT: so_valid=1; the shift register advances one beat per cycle; so_last=1 on the final beat. On the edge ending the final beat:
  - entry tagged end -> DONE;
  - else FIFO non-empty -> pop and stay in SHIFT (zero-gap back-to-back frames);
  - else -> IDLE.
- FSM DONE: done=1 for exactly one cycle, then IDLE. Entries still in the FIFO start on the following cycle.
- Simultaneous push and pop: count is unchanged; legal whenever pi_ready=1.
- Config inputs are sampled only at accept. Changes while a frame is in flight have no effect on it.
- so_data is 0 whenever so_valid=0.
- busy = (count!=0) | (state!=IDLE).

Decomposition:
- Package sti_pkg:
  - pi_length code constants (LEN_HALF, LEN_ONE, LEN_ONE_HALF, LEN_TWO);
  - FSM state enum (IDLE, SHIFT, DONE);
  - function frame_bits(len, DATA_W);
  - FIFO entry struct type.
- One sub-module: sti_cfg_fifo. Synchronous FIFO of entry structs with registered count, full and empty, async active-high reset.
- Frame build, shifter and FSM stay in the top module.

Test Plan:
1. DATA_W=16, LANES=1. Load 16'hA5C3 with len=0, low=0, msb=1 -> 8 beats 1,0,1,0,0,1,0,1. so_valid starts one edge after accept. so_last on beat 8 only.
2. Load 16'h8001 with len=3, fill=1, msb=0 (frame 32'h80010000) -> 32 beats: 16 zeros, 1, 14 zeros, 1. Repeat with len=2, fill=0, msb=1 -> 24 beats: 8 zeros, then 1000000000000001.
3. LANES=4. Load 16'h1234 with len=1, msb=1 -> beats 4'h1, 4'h2, 4'h3, 4'h4. With msb=0 -> 4'h2, 4'hC, 4'h4, 4'h8 (bit-reversed nibbles in reverse order).
4. LANES=1, len=3. Four loads on consecutive cycles -> first three accepted. pi_ready falls after the third. Fourth is dropped and err_ovf=1. so_valid stays high for 96 contiguous beats with so_last on beats 32, 64 and 96.
5. Stream of 3 words, last with pi_end=1 -> done high exactly one cycle, the cycle after the final so_last beat. busy falls together with done. No further so_valid.
6. Reset asserted mid-frame at beat 5 of a 16-beat frame with one entry queued -> so_valid, so_last, busy and pi_ready go 0 asynchronously. After release: pi_ready=1, no beats, no done, err_ovf=0.

Source files
------------

// File: rtl/sti_pkg.sv
// sti_pkg
// Shared definitions for the STI lane serializer: frame length codes, the
// serializer FSM state type, the per-entry framing header carried through the
// input FIFO, and the frame width helper.
package sti_pkg;

  localparam logic [1:0] LEN_HALF     = 2'd0;
  localparam logic [1:0] LEN_ONE      = 2'd1;
  localparam logic [1:0] LEN_ONE_HALF = 2'd2;
  localparam logic [1:0] LEN_TWO      = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sti_state_e;

  // Framing controls captured with each accepted word. The data word itself
  // travels beside this header because its width is a module parameter.
  typedef struct packed {
    logic       eos;
    logic [1:0] length;
    logic       fill;
    logic       msb;
    logic       low;
  } sti_entry_hdr_t;

  function automatic int frame_bits(input logic [1:0] len, input int data_w);
    case (len)
      LEN_HALF:     frame_bits = data_w / 2;
      LEN_ONE:      frame_bits = data_w;
      LEN_ONE_HALF: frame_bits = (3 * data_w) / 2;
      default:      frame_bits = 2 * data_w;
    endcase
  endfunction

endpackage

// File: rtl/sti_cfg_fifo.sv
// sti_cfg_fifo
// Small synchronous FIFO holding accepted words with their framing header.
// Count, full and empty are registered so that downstream ready is glitch-free.
// Ports:
//   clk, reset        clock, async active-high reset (flushes the FIFO)
//   i_push            write strobe (ignored when full)
//   i_wr_hdr/_data    entry to write
//   i_pop             read strobe (ignored when empty)
//   o_rd_hdr/_data    head entry, valid while o_empty=0
//   o_full, o_empty   registered status
module sti_cfg_fifo
  import sti_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_push,
  input  sti_entry_hdr_t    i_wr_hdr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_pop,
  output sti_entry_hdr_t    o_rd_hdr,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_full,
  output logic              o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  sti_entry_hdr_t    r_hdr_mem  [DEPTH];
  logic [DATA_W-1:0] r_data_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_count;
  logic              r_full;
  logic              r_empty;
  logic              w_push;
  logic              w_pop;
  logic [PTR_W:0]    w_count_next;

  assign w_push = i_push & ~r_full;
  assign w_pop  = i_pop & ~r_empty;

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + 1'b1;
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - 1'b1;
    end
  end

  // Storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_hdr_mem[r_wr_ptr]  <= i_wr_hdr;
      r_data_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_next;
      r_full  <= (w_count_next == FULL_CNT);
      r_empty <= (w_count_next == '0);
    end
  end

  assign o_rd_hdr  = r_hdr_mem[r_rd_ptr];
  assign o_rd_data = r_data_mem[r_rd_ptr];
  assign o_full    = r_full;
  assign o_empty   = r_empty;

endmodule

// File: rtl/sti_lane_serializer.sv
// sti_lane_serializer
// Parallel-to-serial transmitter. Accepted words are queued with their framing
// controls, expanded into a frame of F bits and shifted out LANES bits per beat.
// Frames drain back-to-back without gaps; a word tagged end-of-stream is
// followed by a one-cycle done pulse.
// Ports:
//   clk, reset        clock, async active-high reset (aborts any frame)
//   load, pi_*        word offer and its framing controls
//   pi_ready          FIFO can take a word this cycle
//   so_data/valid     serial beat, so_data[LANES-1] is the earliest bit
//   so_last           final beat of the current frame
//   busy              FIFO non-empty or FSM not idle
//   done              one-cycle end-of-stream pulse
//   err_ovf           sticky: load offered while pi_ready=0
//
// state | meaning
// IDLE  | no frame in flight, waiting for a queued entry
// SHIFT | emitting beats of the current frame
// DONE  | end-of-stream frame finished, done pulse is high
module sti_lane_serializer
  import sti_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int LANES      = 1,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] pi_data,
  input  logic [1:0]        pi_length,
  input  logic              pi_fill,
  input  logic              pi_msb,
  input  logic              pi_low,
  input  logic              pi_end,
  output logic              pi_ready,
  output logic [LANES-1:0]  so_data,
  output logic              so_valid,
  output logic              so_last,
  output logic              busy,
  output logic              done,
  output logic              err_ovf
);

  localparam int HALF_W    = DATA_W / 2;
  localparam int SR_W      = 2 * DATA_W;
  localparam int MAX_BEATS = SR_W / LANES;
  localparam int CNT_W     = $clog2(MAX_BEATS);

  sti_state_e        r_state;
  logic [SR_W-1:0]   r_shift;
  logic [CNT_W-1:0]  r_beat_cnt;
  logic              r_cur_eos;
  logic              r_so_valid;
  logic              r_so_last;
  logic              r_done;
  logic              r_err_ovf;
  logic              r_ready_en;

  sti_entry_hdr_t    w_wr_hdr;
  sti_entry_hdr_t    w_rd_hdr;
  logic [DATA_W-1:0] w_rd_data;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_frame_done;
  logic [SR_W-1:0]   w_frame;
  logic [SR_W-1:0]   w_aligned;
  int                w_frame_bits;
  logic [CNT_W-1:0]  w_beats_m1;

  assign w_wr_hdr = '{eos: pi_end, length: pi_length, fill: pi_fill, msb: pi_msb, low: pi_low};

  // r_ready_en keeps pi_ready low through reset and releases it on the first
  // edge afterwards, while the FIFO status itself comes out of reset not-full.
  assign pi_ready = r_ready_en & ~w_fifo_full;
  assign w_push   = load & pi_ready;

  assign w_frame_done = (r_state == SHIFT) && (r_beat_cnt == '0);
  assign w_pop = ~w_fifo_empty & ((r_state == IDLE) | (w_frame_done & ~r_cur_eos));

  sti_cfg_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .i_push    (w_push),
    .i_wr_hdr  (w_wr_hdr),
    .i_wr_data (pi_data),
    .i_pop     (w_pop),
    .o_rd_hdr  (w_rd_hdr),
    .o_rd_data (w_rd_data),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty)
  );

  // Frame value occupies the low F bits of w_frame.
  always_comb begin
    w_frame = '0;
    case (w_rd_hdr.length)
      LEN_HALF: w_frame[HALF_W-1:0] = w_rd_hdr.low ? w_rd_data[HALF_W-1:0]
                                                   : w_rd_data[DATA_W-1:HALF_W];
      LEN_ONE:  w_frame[DATA_W-1:0] = w_rd_data;
      LEN_ONE_HALF: begin
        if (w_rd_hdr.fill) w_frame[HALF_W +: DATA_W] = w_rd_data;
        else               w_frame[DATA_W-1:0]       = w_rd_data;
      end
      default: begin
        if (w_rd_hdr.fill) w_frame[DATA_W +: DATA_W] = w_rd_data;
        else               w_frame[DATA_W-1:0]       = w_rd_data;
      end
    endcase
  end

  assign w_frame_bits = frame_bits(w_rd_hdr.length, DATA_W);
  assign w_beats_m1   = CNT_W'(w_frame_bits / LANES - 1);

  // Place the first bit to send at the top of the shift register so every
  // frame shifts out the same way: MSB-first left-justifies the frame,
  // LSB-first bit-reverses the whole register.
  always_comb begin
    w_aligned = '0;
    if (w_rd_hdr.msb) begin
      w_aligned = w_frame << (SR_W - w_frame_bits);
    end else begin
      for (int i = 0; i < SR_W; i++) begin
        w_aligned[SR_W-1-i] = w_frame[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_beat_cnt <= '0;
      r_cur_eos  <= 1'b0;
      r_so_valid <= 1'b0;
      r_so_last  <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: ;
        SHIFT: begin
          if (!w_frame_done) begin
            r_shift    <= r_shift << LANES;
            r_beat_cnt <= r_beat_cnt - 1'b1;
            r_so_last  <= (r_beat_cnt == CNT_W'(1));
          end else begin
            r_shift    <= '0;
            r_so_valid <= 1'b0;
            r_so_last  <= 1'b0;
            r_done     <= r_cur_eos;
            r_state    <= r_cur_eos ? DONE : IDLE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
      // A pop starts the next frame and overrides the frame-end clearing above.
      if (w_pop) begin
        r_state    <= SHIFT;
        r_shift    <= w_aligned;
        r_beat_cnt <= w_beats_m1;
        r_so_last  <= (w_beats_m1 == '0);
        r_so_valid <= 1'b1;
        r_cur_eos  <= w_rd_hdr.eos;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_ovf  <= 1'b0;
      r_ready_en <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
      if (load && !pi_ready) r_err_ovf <= 1'b1;
    end
  end

  assign so_data  = r_shift[SR_W-1 -: LANES] & {LANES{r_so_valid}};
  assign so_valid = r_so_valid;
  assign so_last  = r_so_last;
  assign done     = r_done;
  assign err_ovf  = r_err_ovf;
  assign busy     = ~w_fifo_empty | (r_state != IDLE);

endmodule

// File: tb/tb_sti_lane_serializer.sv
module tb_sti_lane_serializer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load1 = 1'b0;
  logic        load4 = 1'b0;
  logic [15:0] pi_data = '0;
  logic [1:0]  pi_length = '0;
  logic        pi_fill = 1'b0;
  logic        pi_msb = 1'b0;
  logic        pi_low = 1'b0;
  logic        pi_end = 1'b0;

  logic       rdy1, sv1, sl1, busy1, done1, ovf1;
  logic [0:0] sd1;
  logic       rdy4, sv4, sl4, busy4, done4, ovf4;
  logic [3:0] sd4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sti_lane_serializer #(.DATA_W(16), .LANES(1), .FIFO_DEPTH(2)) u_dut1 (
    .clk(clk), .reset(reset), .load(load1), .pi_data(pi_data), .pi_length(pi_length),
    .pi_fill(pi_fill), .pi_msb(pi_msb), .pi_low(pi_low), .pi_end(pi_end),
    .pi_ready(rdy1), .so_data(sd1), .so_valid(sv1), .so_last(sl1),
    .busy(busy1), .done(done1), .err_ovf(ovf1)
  );

  sti_lane_serializer #(.DATA_W(16), .LANES(4), .FIFO_DEPTH(2)) u_dut4 (
    .clk(clk), .reset(reset), .load(load4), .pi_data(pi_data), .pi_length(pi_length),
    .pi_fill(pi_fill), .pi_msb(pi_msb), .pi_low(pi_low), .pi_end(pi_end),
    .pi_ready(rdy4), .so_data(sd4), .so_valid(sv4), .so_last(sl4),
    .busy(busy4), .done(done4), .err_ovf(ovf4)
  );

  task automatic set_cfg(input logic [15:0] d, input logic [1:0] len, input logic fill,
                         input logic msb, input logic low, input logic eos);
    pi_data = d; pi_length = len; pi_fill = fill; pi_msb = msb; pi_low = low; pi_end = eos;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({rdy1, sd1, sv1, sl1, busy1, done1, ovf1} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs_l1: got %b expected 0000000",
               {rdy1, sd1, sv1, sl1, busy1, done1, ovf1});
    end
    checks++;
    if ({rdy4, sd4, sv4, sl4, busy4, done4, ovf4} !== 10'b0) begin
      errors++;
      $display("FAIL reset_outputs_l4: got %b expected 0", {rdy4, sd4, sv4, sl4, busy4, done4, ovf4});
    end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (rdy1 !== 1'b1 || rdy4 !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: got %b%b expected 11", rdy1, rdy4);
    end
  endtask

  task automatic test_half_frame;
    logic [7:0] exp_seq;
    exp_seq = 8'b1010_0101;
    @(posedge clk); #1;
    set_cfg(16'hA5C3, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    load1 = 1'b1;
    @(posedge clk); #1;
    load1 = 1'b0;
    checks++;
    if (sv1 !== 1'b0 || busy1 !== 1'b1) begin
      errors++;
      $display("FAIL half_latency: valid %b busy %b expected valid 0 busy 1", sv1, busy1);
    end
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({sv1, sd1, sl1} !== {1'b1, exp_seq[7-i], (i == 7)}) begin
        errors++;
        $display("FAIL half_beat%0d: got v/d/l %b%b%b expected 1%b%b", i + 1, sv1, sd1, sl1,
                 exp_seq[7-i], (i == 7));
      end
    end
    @(posedge clk); #1;
    checks++;
    if (sv1 !== 1'b0 || sd1 !== 1'b0 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL half_end: valid %b data %b busy %b expected 000", sv1, sd1, busy1);
    end
  endtask

  task automatic test_long_frames;
    logic [1:0]  t_len  [2] = '{2'd3, 2'd2};
    logic        t_fill [2] = '{1'b1, 1'b0};
    logic        t_msb  [2] = '{1'b0, 1'b1};
    int          t_n    [2] = '{32, 24};
    logic [31:0] seq;
    int          n;
    seq = 32'h0000_8001;
    for (int r = 0; r < 2; r++) begin
      n = t_n[r];
      @(posedge clk); #1;
      set_cfg(16'h8001, t_len[r], t_fill[r], t_msb[r], 1'b0, 1'b0);
      load1 = 1'b1;
      @(posedge clk); #1;
      load1 = 1'b0;
      for (int i = 0; i < n; i++) begin
        @(posedge clk); #1;
        checks++;
        if ({sv1, sd1, sl1} !== {1'b1, seq[n-1-i], (i == n - 1)}) begin
          errors++;
          $display("FAIL long%0d_beat%0d: got v/d/l %b%b%b expected 1%b%b", r, i + 1, sv1, sd1, sl1,
                   seq[n-1-i], (i == n - 1));
        end
      end
      @(posedge clk); #1;
      checks++;
      if (sv1 !== 1'b0 || busy1 !== 1'b0) begin
        errors++;
        $display("FAIL long%0d_end: valid %b busy %b expected 00", r, sv1, busy1);
      end
    end
  endtask

  task automatic test_lanes4;
    logic        t_msb [2] = '{1'b1, 1'b0};
    logic [15:0] t_exp [2] = '{16'h1234, 16'h2C48};
    logic [15:0] e;
    for (int r = 0; r < 2; r++) begin
      e = t_exp[r];
      @(posedge clk); #1;
      set_cfg(16'h1234, 2'd1, 1'b0, t_msb[r], 1'b0, 1'b0);
      load4 = 1'b1;
      @(posedge clk); #1;
      load4 = 1'b0;
      for (int i = 0; i < 4; i++) begin
        @(posedge clk); #1;
        checks++;
        if (sv4 !== 1'b1 || sd4 !== e[15-4*i -: 4] || sl4 !== (i == 3)) begin
          errors++;
          $display("FAIL lanes4_%0d_beat%0d: got v %b d %h l %b expected v 1 d %h l %b", r, i + 1,
                   sv4, sd4, sl4, e[15-4*i -: 4], (i == 3));
        end
      end
      @(posedge clk); #1;
      checks++;
      if (sv4 !== 1'b0 || sd4 !== 4'h0) begin
        errors++;
        $display("FAIL lanes4_%0d_end: valid %b data %h expected 0 0", r, sv4, sd4);
      end
    end
  endtask

  task automatic test_overflow;
    logic [15:0] words [4] = '{16'hC001, 16'h1234, 16'h8421, 16'hFFFF};
    logic        exp_rdy [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic        exp_ovf [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    int          beat, pos, k;
    logic        exp_bit;
    bit          stop;
    beat = 0;
    stop = 1'b0;
    @(posedge clk); #1;
    set_cfg(words[0], 2'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    load1 = 1'b1;
    for (int c = 0; c < 200 && !stop; c++) begin
      @(posedge clk); #1;
      if (c < 3) pi_data = words[c+1];
      else load1 = 1'b0;
      if (c < 4) begin
        checks++;
        if (rdy1 !== exp_rdy[c] || ovf1 !== exp_ovf[c]) begin
          errors++;
          $display("FAIL ovf_edge%0d: ready %b ovf %b expected %b %b", c + 1, rdy1, ovf1,
                   exp_rdy[c], exp_ovf[c]);
        end
      end
      if (sv1 === 1'b1 && beat < 128) begin
        pos = beat % 32;
        k = beat / 32;
        beat++;
        exp_bit = (pos < 16) ? words[k][15-pos] : 1'b0;
        checks++;
        if (sd1 !== exp_bit || sl1 !== (pos == 31)) begin
          errors++;
          $display("FAIL ovf_beat%0d: data %b last %b expected %b %b", beat, sd1, sl1, exp_bit,
                   (pos == 31));
        end
      end else if (beat > 0) begin
        stop = 1'b1;
      end
    end
    checks++;
    if (beat != 96 || ovf1 !== 1'b1) begin
      errors++;
      $display("FAIL ovf_total: beats %0d ovf %b expected 96 1", beat, ovf1);
    end
  endtask

  task automatic test_end_of_stream;
    int beat;
    bit stop;
    beat = 0;
    stop = 1'b0;
    @(posedge clk); #1;
    set_cfg(16'hF00F, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    load1 = 1'b1;
    for (int c = 0; c < 60 && !stop; c++) begin
      @(posedge clk); #1;
      if (c == 0) pi_data = 16'h3C3C;
      if (c == 1) begin pi_data = 16'h0FF0; pi_end = 1'b1; end
      if (c == 2) begin load1 = 1'b0; pi_end = 1'b0; end
      if (sv1 === 1'b1) begin
        beat++;
        checks++;
        if (sl1 !== (beat % 8 == 0) || done1 !== 1'b0) begin
          errors++;
          $display("FAIL eos_beat%0d: last %b done %b expected %b 0", beat, sl1, done1,
                   (beat % 8 == 0));
        end
      end else if (beat > 0) begin
        stop = 1'b1;
      end
    end
    checks++;
    if (beat != 24 || done1 !== 1'b1 || busy1 !== 1'b1) begin
      errors++;
      $display("FAIL eos_done: beats %0d done %b busy %b expected 24 1 1", beat, done1, busy1);
    end
    @(posedge clk); #1;
    checks++;
    if (done1 !== 1'b0 || busy1 !== 1'b0 || sv1 !== 1'b0) begin
      errors++;
      $display("FAIL eos_after: done %b busy %b valid %b expected 000", done1, busy1, sv1);
    end
    stop = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (sv1 !== 1'b0 || done1 !== 1'b0) stop = 1'b1;
    end
    checks++;
    if (stop) begin
      errors++;
      $display("FAIL eos_quiet: activity after done, valid %b done %b expected 0 0", sv1, done1);
    end
  endtask

  task automatic test_reset_mid_frame;
    int  beat;
    bit  seen;
    beat = 0;
    @(posedge clk); #1;
    set_cfg(16'hFFFF, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    load1 = 1'b1;
    @(posedge clk); #1;
    pi_data = 16'h5555;
    @(posedge clk); #1;
    load1 = 1'b0;
    if (sv1 === 1'b1) beat = 1;
    for (int c = 0; c < 10 && beat < 5; c++) begin
      @(posedge clk); #1;
      if (sv1 === 1'b1) beat++;
    end
    checks++;
    if (beat != 5 || busy1 !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_setup: beats %0d busy %b expected 5 1", beat, busy1);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({sv1, sl1, busy1, rdy1, done1} !== 5'b0) begin
      errors++;
      $display("FAIL rst_mid_async: v/l/busy/rdy/done %b expected 00000", {sv1, sl1, busy1, rdy1, done1});
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (rdy1 !== 1'b1 || ovf1 !== 1'b0 || sv1 !== 1'b0 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_release: rdy %b ovf %b valid %b busy %b expected 1000", rdy1, ovf1, sv1, busy1);
    end
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (sv1 !== 1'b0 || done1 !== 1'b0 || sl1 !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL rst_mid_quiet: beats or done after reset, valid %b done %b expected 0 0", sv1, done1);
    end
  endtask

  initial begin
    test_reset();
    test_half_frame();
    test_long_frames();
    test_lanes4();
    test_overflow();
    test_end_of_stream();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
